// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame length, parity helper and
// common command bytes for the host transmitter and keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_BITS,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_e;

    // start + 8 data + parity + stop
    localparam int FRAME_LEN = 11;

    localparam logic [7:0] CMD_SET_LED   = 8'hED;
    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] RSP_ACK       = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data pins plus a falling-edge
// detector on the synchronised clock. Shared with the keyboard receiver.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_s_o,
    output logic data_s_o,
    output logic clk_fall_o
);

    logic [1:0] clk_meta_q;
    logic [1:0] data_meta_q;
    logic       clk_prev_q;

    // Reset to the idle-high bus level so no spurious edge follows reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q  <= 2'b11;
            data_meta_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_meta_q  <= {clk_meta_q[0], ps2_clk_i};
            data_meta_q <= {data_meta_q[0], ps2_data_i};
            clk_prev_q  <= clk_meta_q[1];
        end
    end

    assign clk_s_o    = clk_meta_q[1];
    assign data_s_o   = data_meta_q[1];
    assign clk_fall_o = clk_prev_q & ~clk_meta_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame, ACK check.
// Define PS2_HOST_TX_RETRY_EN to resend a failed byte once before reporting.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | lines released, accepting a byte
// INHIBIT    | clock held low for INHIBIT_CYCLES
// START      | clock and data low for one cycle (start bit)
// BITS       | clock released, device clocks out data/parity/stop
// ACK        | lines released, waiting for the device ACK clock
// WAIT_IDLE  | waiting for both lines high before reporting
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(FRAME_LEN);

    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_BIT_IDX = IDX_W'(FRAME_LEN - 2);

    logic clk_s;
    logic data_s;
    logic clk_fall;

    ps2_line_sync u_sync (
        .clk        (clk),
        .rst_n      (resetn),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .clk_s_o    (clk_s),
        .data_s_o   (data_s),
        .clk_fall_o (clk_fall)
    );

    ps2_state_e             state_q, state_d;
    logic [FRAME_LEN-1:0]   frame_q, frame_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   nack_q, nack_d;
    logic                   clk_oe_q, clk_oe_d;
    logic                   data_oe_q, data_oe_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   fail_evt;
`ifdef PS2_HOST_TX_RETRY_EN
    logic                   retried_q, retried_d;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            nack_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            nack_q    <= nack_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef PS2_HOST_TX_RETRY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            retried_q <= 1'b0;
        end else begin
            retried_q <= retried_d;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        nack_d   = nack_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        fail_evt = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        retried_d = retried_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    frame_d = {1'b1, odd_parity(tx_data), tx_data, 1'b0};
                    state_d = ST_INHIBIT;
                    cnt_d   = INHIBIT_LOAD;
                    nack_d  = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
                    retried_d = 1'b0;
`endif
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_START: begin
                state_d = ST_BITS;
                idx_d   = '0;
                cnt_d   = TIMEOUT_LOAD;
            end
            ST_BITS: begin
                // A fall in the same cycle as terminal count still advances.
                if (clk_fall) begin
                    cnt_d = TIMEOUT_LOAD;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_BIT_IDX) begin
                        state_d = ST_ACK;
                    end
                end else if (cnt_q == '0) begin
                    fail_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    nack_d  = data_s;
                    cnt_d   = TIMEOUT_LOAD;
                    state_d = ST_WAIT_IDLE;
                end else if (cnt_q == '0) begin
                    fail_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    if (nack_q) begin
                        fail_evt = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (clk_fall) begin
                    cnt_d = TIMEOUT_LOAD;
                end else if (cnt_q == '0) begin
                    fail_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fail_evt) begin
`ifdef PS2_HOST_TX_RETRY_EN
            if (!retried_q) begin
                retried_d = 1'b1;
                nack_d    = 1'b0;
                state_d   = ST_INHIBIT;
                cnt_d     = INHIBIT_LOAD;
            end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
`endif
        end

        // Pin drives are registered from the next state so they never glitch.
        clk_oe_d  = (state_d == ST_INHIBIT) || (state_d == ST_START);
        data_oe_d = (state_d == ST_START) || ((state_d == ST_BITS) && !frame_d[idx_d]);
    end

    assign tx_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx against a behavioural PS/2 keyboard model.
module tb_ps2_host_tx;

    localparam int INH       = 5000;
    localparam int TO        = 2000;
    localparam int HALF      = 20;
    localparam int DEV_SETUP = 10;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam int NACK_FRAMES = 2;
`else
    localparam int NACK_FRAMES = 1;
`endif

    localparam int DEV_ACK    = 0;
    localparam int DEV_NACK   = 1;
    localparam int DEV_SILENT = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic clk_line;
    logic data_line;
    assign clk_line  = !(ps2_clk_oe || dev_clk_low);
    assign data_line = !(ps2_data_oe || dev_data_low);

    int       dev_mode = DEV_ACK;
    bit       dev_abort = 1'b0;
    bit       dev_active = 1'b0;
    int       dev_falls = 0;
    int       frames_seen = 0;
    logic [9:0] rx_bits = '0;
    int       last_rel = 0;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       err;
        int         frames;
        int         base;
        bit         chk_to;
    } exp_t;
    exp_t sb_q[$];

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_i   (clk_line),
        .ps2_data_i  (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Keyboard model: clocks the frame out, samples each bit at the end of
    // the low phase, then ACKs (or not) on the 11th clock.
    task automatic dev_frame();
        logic [9:0] bits;
        bits = '0;
        dev_active = 1'b1;
        dev_falls = 0;
        repeat (DEV_SETUP) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            dev_clk_low = 1'b1;
            dev_falls++;
            repeat (HALF) @(negedge clk);
            bits[k] = data_line;
            dev_clk_low = 1'b0;
            if (dev_abort) begin
                dev_active = 1'b0;
                return;
            end
            repeat (HALF) @(negedge clk);
            if (dev_abort) begin
                dev_active = 1'b0;
                return;
            end
        end
        if (dev_mode == DEV_ACK) dev_data_low = 1'b1;
        repeat (4) @(negedge clk);
        dev_clk_low = 1'b1;
        dev_falls++;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        rx_bits = bits;
        frames_seen++;
        dev_active = 1'b0;
    endtask

    initial begin
        logic clk_prev;
        clk_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (clk_line && !clk_prev && !data_line && !dev_abort && dev_mode != DEV_SILENT)
                dev_frame();
            clk_prev = clk_line;
        end
    end

    // Monitor: pops one expected transaction per done pulse.
    initial begin
        int   cyc;
        logic oe_prev;
        exp_t e;
        cyc = 0;
        oe_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (oe_prev && !ps2_clk_oe) last_rel = cyc;
            oe_prev = ps2_clk_oe;
            if (resetn && done) begin
                check("done_has_pending_item", int'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("err", int'(err), int'(e.err));
                    check("tx_ready_at_done", int'(tx_ready), 1);
                    check("frames_on_wire", frames_seen - e.base, e.frames);
                    if (e.frames > 0) begin
                        check("rx_byte", int'(rx_bits[7:0]), int'(e.data));
                        check("rx_parity", int'(rx_bits[8]), int'(e.par));
                        check("rx_stop", int'(rx_bits[9]), 1);
                    end
                    if (e.chk_to) begin
                        check("timeout_cycles", cyc - last_rel, TO);
                        check("timeout_clk_oe", int'(ps2_clk_oe), 0);
                        check("timeout_data_oe", int'(ps2_data_oe), 0);
                    end
                end
            end
        end
    end

    task automatic start_send(input logic [7:0] d, input logic par, input logic e_err,
                              input int e_frames, input bit chk_to, input bit push,
                              input bit chk_timing);
        int n_inh;
        int n_start;
        exp_t e;
        @(negedge clk);
        check("ready_before_send", int'(tx_ready), 1);
        tx_data = d;
        tx_valid = 1'b1;
        if (push) begin
            e.data = d; e.par = par; e.err = e_err; e.frames = e_frames;
            e.base = frames_seen; e.chk_to = chk_to;
            sb_q.push_back(e);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        check("ready_low_after_accept", int'(tx_ready), 0);
        check("busy_after_accept", int'(busy), 1);
        if (chk_timing) begin
            n_inh = 0;
            n_start = 0;
            while (ps2_clk_oe && !ps2_data_oe && n_inh < 4 * INH) begin
                n_inh++;
                @(negedge clk);
            end
            while (ps2_clk_oe && ps2_data_oe && n_start < 10) begin
                n_start++;
                @(negedge clk);
            end
            check("inhibit_cycles", n_inh, INH);
            check("start_cycles", n_start, 1);
            check("released_clk_oe", int'(ps2_clk_oe), 0);
            check("released_data_oe", int'(ps2_data_oe), 1);
        end
    endtask

    task automatic wait_sb_empty(input int bound);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", int'(sb_q.size() == 0), 1);
        repeat (50) @(negedge clk);
    endtask

    initial begin
        int  n;
        bit  busy_seen;
        resetn = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tx_ready", int'(tx_ready), 1);
        check("rst_clk_oe", int'(ps2_clk_oe), 0);
        check("rst_data_oe", int'(ps2_data_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        dev_mode = DEV_ACK;
        start_send(8'hED, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1);
        wait_sb_empty(30000);

        start_send(8'h01, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        wait_sb_empty(30000);

        dev_mode = DEV_NACK;
        start_send(8'hF4, 1'b0, 1'b1, NACK_FRAMES, 1'b0, 1'b1, 1'b0);
        wait_sb_empty(30000);

        dev_mode = DEV_SILENT;
        start_send(8'hED, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        wait_sb_empty(30000);

        dev_mode = DEV_ACK;
        dev_falls = 0;
        start_send(8'hF3, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (dev_falls < 4 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("fall4_reached", int'(dev_falls >= 4), 1);
        repeat (6) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        check("pre_reset_data_oe_bit3", int'(ps2_data_oe), 1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_clk_oe", int'(ps2_clk_oe), 0);
        check("async_rst_data_oe", int'(ps2_data_oe), 0);
        check("async_rst_tx_ready", int'(tx_ready), 1);
        dev_abort = 1'b1;
        n = 0;
        while (dev_active && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        resetn = 1'b1;
        dev_abort = 1'b0;
        repeat (20) @(negedge clk);
        start_send(8'hFF, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        wait_sb_empty(30000);

        start_send(8'h3C, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        repeat (100) @(negedge clk);
        tx_data = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk);
        check("busy_ignores_valid_ready", int'(tx_ready), 0);
        tx_valid = 1'b0;
        wait_sb_empty(30000);
        busy_seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        check("nothing_queued", int'(busy_seen), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
